// File: rtl/square_dds_pkg.sv
// Shared definitions for the N-channel square-wave DDS.
//   state_t       : top-level run/idle state
//   DEF_ACC_W     : default accumulator / config word width
//   DEF_PHASE_MOD : default accumulator modulus (clock rate, so words are in Hz)
package square_dds_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned DEF_ACC_W     = 32;
  localparam int unsigned DEF_PHASE_MOD = 50_000_000;

endpackage

// File: rtl/square_dds_channel.sv
// One square-wave DDS channel: modulo-PHASE_MOD phase accumulator, duty
// comparator and wrap detection.
//   clk_in, rst_n : clock, async active-low reset
//   run           : advance the accumulator and drive sq/wrap (else both 0)
//   load          : load acc with phase (reduced once modulo PHASE_MOD)
//   phase/freq/duty : active configuration for this channel
//   sq            : registered square output (acc < duty)
//   wrap          : registered one-cycle wrap pulse
//   wrap_next     : combinational "this edge wraps" flag, used for commit timing
module square_dds_channel
  import square_dds_pkg::*;
#(
  parameter int unsigned ACC_W     = DEF_ACC_W,
  parameter int unsigned PHASE_MOD = DEF_PHASE_MOD
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             run,
  input  logic             load,
  input  logic [ACC_W-1:0] phase,
  input  logic [ACC_W-1:0] freq,
  input  logic [ACC_W-1:0] duty,
  output logic             sq,
  output logic             wrap,
  output logic             wrap_next
);

  localparam logic [ACC_W:0]   MOD_X = (ACC_W+1)'(PHASE_MOD);
  localparam logic [ACC_W-1:0] MOD_A = ACC_W'(PHASE_MOD);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_step;
  logic [ACC_W-1:0] phase_red;
  logic [ACC_W:0]   sum;

  // Sum carried at ACC_W+1 bits so acc + freq cannot overflow before the compare.
  always_comb begin
    sum       = {1'b0, acc} + {1'b0, freq};
    wrap_next = (sum >= MOD_X);
    acc_step  = wrap_next ? ACC_W'(sum - MOD_X) : ACC_W'(sum);
    phase_red = (phase >= MOD_A) ? (phase - MOD_A) : phase;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      sq   <= 1'b0;
      wrap <= 1'b0;
    end else begin
      if (run) begin
        sq   <= (acc < duty);
        wrap <= wrap_next;
      end else begin
        sq   <= 1'b0;
        wrap <= 1'b0;
      end
      if (load) begin
        acc <= phase_red;
      end else if (run) begin
        acc <= acc_step;
      end
    end
  end

endmodule

// File: rtl/square_dds_nch.sv
// N-channel square-wave DDS for lock-in reference generation.
// Double-buffered configuration: cfg_wr fills per-channel shadow registers,
// cfg_commit transfers all shadows to the active bank (immediately in IDLE,
// at the next channel-0 wrap in RUN so every channel restarts phase-coherently).
//   clk_in, rst_n     : clock, async active-low reset
//   out_en            : run enable (level)
//   cfg_wr, cfg_ch    : shadow write strobe / target channel (>= N_CH ignored)
//   cfg_freq/phase/duty : shadow write data
//   cfg_commit        : request shadow->active transfer for all channels
//   commit_busy       : commit pending in RUN
//   running           : registered state == RUN
//   sq_out            : square outputs, one per channel
//   wrap_pulse        : one-cycle pulse per channel accumulator wrap
module square_dds_nch
  import square_dds_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned ACC_W     = DEF_ACC_W,
  parameter int unsigned PHASE_MOD = DEF_PHASE_MOD,
  parameter int unsigned CH_IDX_W  = 4
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                out_en,
  input  logic                cfg_wr,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [ACC_W-1:0]    cfg_freq,
  input  logic [ACC_W-1:0]    cfg_phase,
  input  logic [ACC_W-1:0]    cfg_duty,
  input  logic                cfg_commit,
  output logic                commit_busy,
  output logic                running,
  output logic [N_CH-1:0]     sq_out,
  output logic [N_CH-1:0]     wrap_pulse
);

  logic [ACC_W-1:0] sh_freq      [N_CH];
  logic [ACC_W-1:0] sh_phase     [N_CH];
  logic [ACC_W-1:0] sh_duty      [N_CH];
  logic [ACC_W-1:0] sh_freq_nxt  [N_CH];
  logic [ACC_W-1:0] sh_phase_nxt [N_CH];
  logic [ACC_W-1:0] sh_duty_nxt  [N_CH];
  logic [ACC_W-1:0] act_freq     [N_CH];
  logic [ACC_W-1:0] act_phase    [N_CH];
  logic [ACC_W-1:0] act_duty     [N_CH];
  logic [ACC_W-1:0] ch_phase     [N_CH];

  logic [N_CH-1:0] wrap_next;
  logic            unused_wrap_next;

  state_t state, state_nxt;
  logic   run_ch;
  logic   ch_load;
  logic   apply_wrap;
  logic   copy_active;
  logic   busy_nxt;

  // Shadow view including this cycle's write, so a same-cycle commit sees it.
  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      sh_freq_nxt[i]  = sh_freq[i];
      sh_phase_nxt[i] = sh_phase[i];
      sh_duty_nxt[i]  = sh_duty[i];
      if (cfg_wr && (cfg_ch == CH_IDX_W'(i))) begin
        sh_freq_nxt[i]  = cfg_freq;
        sh_phase_nxt[i] = cfg_phase;
        sh_duty_nxt[i]  = cfg_duty;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (out_en)  state_nxt = RUN;
      RUN:     if (!out_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    run_ch      = (state == RUN) && out_en;
    apply_wrap  = run_ch && commit_busy && wrap_next[0];
    copy_active = 1'b0;
    busy_nxt    = 1'b0;
    unique case (state)
      IDLE: copy_active = cfg_commit;
      RUN: begin
        if (!out_en) begin
          // Leaving RUN: any pending or fresh commit is applied on entry to IDLE.
          copy_active = commit_busy || cfg_commit;
        end else begin
          copy_active = apply_wrap;
          busy_nxt    = !apply_wrap && (commit_busy || cfg_commit);
        end
      end
      default: ;
    endcase
    // Outside RUN the accumulators track the active phase every cycle.
    ch_load = !run_ch || apply_wrap;
    for (int unsigned i = 0; i < N_CH; i++) begin
      ch_phase[i] = apply_wrap ? sh_phase_nxt[i] : act_phase[i];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      commit_busy <= 1'b0;
      running     <= 1'b0;
    end else begin
      commit_busy <= busy_nxt;
      running     <= (state_nxt == RUN);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        sh_freq[i]   <= '0;
        sh_phase[i]  <= '0;
        sh_duty[i]   <= '0;
        act_freq[i]  <= '0;
        act_phase[i] <= '0;
        act_duty[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        sh_freq[i]  <= sh_freq_nxt[i];
        sh_phase[i] <= sh_phase_nxt[i];
        sh_duty[i]  <= sh_duty_nxt[i];
        if (copy_active) begin
          act_freq[i]  <= sh_freq_nxt[i];
          act_phase[i] <= sh_phase_nxt[i];
          act_duty[i]  <= sh_duty_nxt[i];
        end
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    square_dds_channel #(
      .ACC_W     (ACC_W),
      .PHASE_MOD (PHASE_MOD)
    ) u_ch (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .run       (run_ch),
      .load      (ch_load),
      .phase     (ch_phase[g]),
      .freq      (act_freq[g]),
      .duty      (act_duty[g]),
      .sq        (sq_out[g]),
      .wrap      (wrap_pulse[g]),
      .wrap_next (wrap_next[g])
    );
  end

  // Only channel 0's wrap times the commit.
  assign unused_wrap_next = ^wrap_next;

endmodule

// File: tb/tb_square_dds_nch.sv
module tb_square_dds_nch;

  localparam int NC  = 4;
  localparam int MOD = 100;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        out_en = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [3:0]  cfg_ch = '0;
  logic [31:0] cfg_freq = '0;
  logic [31:0] cfg_phase = '0;
  logic [31:0] cfg_duty = '0;
  logic        cfg_commit = 1'b0;
  logic        commit_busy;
  logic        running;
  logic [3:0]  sq_out;
  logic [3:0]  wrap_pulse;

  square_dds_nch #(
    .N_CH      (4),
    .ACC_W     (32),
    .PHASE_MOD (100),
    .CH_IDX_W  (4)
  ) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .out_en      (out_en),
    .cfg_wr      (cfg_wr),
    .cfg_ch      (cfg_ch),
    .cfg_freq    (cfg_freq),
    .cfg_phase   (cfg_phase),
    .cfg_duty    (cfg_duty),
    .cfg_commit  (cfg_commit),
    .commit_busy (commit_busy),
    .running     (running),
    .sq_out      (sq_out),
    .wrap_pulse  (wrap_pulse)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [3:0] sq;
    logic [3:0] wr;
    logic       busy;
    logic       run;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] sq_hist[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  // Reference model state (spec-level behaviour, integer arithmetic).
  int         m_sf[NC], m_sp[NC], m_sd[NC];
  int         m_af[NC], m_ap[NC], m_ad[NC];
  int         m_acc[NC];
  logic [3:0] m_sq, m_wr;
  bit         m_run, m_busy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc%0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int red(input int p);
    return (p >= MOD) ? p - MOD : p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_sf[i] = 0; m_sp[i] = 0; m_sd[i] = 0;
      m_af[i] = 0; m_ap[i] = 0; m_ad[i] = 0;
      m_acc[i] = 0;
    end
    m_sq = '0; m_wr = '0; m_run = 0; m_busy = 0;
  endtask

  // Advance the model by one edge using the inputs presented now, and queue
  // the outputs the DUT must show after that edge.
  task automatic model_step();
    int sf[NC], sp[NC], sd[NC];
    int s;
    bit w0;
    exp_t e;
    for (int i = 0; i < NC; i++) begin
      sf[i] = m_sf[i]; sp[i] = m_sp[i]; sd[i] = m_sd[i];
    end
    if (cfg_wr && cfg_ch < NC) begin
      sf[cfg_ch] = cfg_freq; sp[cfg_ch] = cfg_phase; sd[cfg_ch] = cfg_duty;
    end
    if (!m_run || !out_en) begin
      for (int i = 0; i < NC; i++) m_acc[i] = red(m_ap[i]);
      m_sq = '0; m_wr = '0;
      if (cfg_commit || (m_run && m_busy)) begin
        for (int i = 0; i < NC; i++) begin
          m_af[i] = sf[i]; m_ap[i] = sp[i]; m_ad[i] = sd[i];
        end
      end
      m_busy = 0;
      m_run  = out_en;
    end else begin
      w0 = (m_acc[0] + m_af[0]) >= MOD;
      for (int i = 0; i < NC; i++) begin
        m_sq[i] = (m_acc[i] < m_ad[i]);
        s = m_acc[i] + m_af[i];
        m_wr[i] = (s >= MOD);
        m_acc[i] = m_wr[i] ? s - MOD : s;
      end
      if (m_busy && w0) begin
        for (int i = 0; i < NC; i++) begin
          m_af[i] = sf[i]; m_ap[i] = sp[i]; m_ad[i] = sd[i];
          m_acc[i] = red(sp[i]);
        end
        m_busy = 0;
      end else if (cfg_commit) begin
        m_busy = 1;
      end
    end
    for (int i = 0; i < NC; i++) begin
      m_sf[i] = sf[i]; m_sp[i] = sp[i]; m_sd[i] = sd[i];
    end
    e.sq = m_sq; e.wr = m_wr; e.busy = m_busy; e.run = m_run;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_in);
    #2;
    cfg_wr = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic write(input int ch, input int f, input int p, input int d);
    cfg_ch = 4'(ch); cfg_freq = 32'(f); cfg_phase = 32'(p); cfg_duty = 32'(d);
    cfg_wr = 1'b1;
    tick();
  endtask

  // Monitor: pops one expectation per clock whenever one is outstanding.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        sq_hist.push_back(sq_out);
        chk("sq_out",      32'(sq_out),      32'(e.sq));
        chk("wrap_pulse",  32'(wrap_pulse),  32'(e.wr));
        chk("commit_busy", 32'(commit_busy), 32'(e.busy));
        chk("running",     32'(running),     32'(e.run));
      end
    end
  end

  // Hand-derived sq_out {ch3,ch2,ch1,ch0} from the enabling edge onward.
  logic [3:0] first_tbl [12] = '{4'b0000, 4'b1011, 4'b1011, 4'b1001, 4'b1001, 4'b1011,
                                 4'b1010, 4'b1010, 4'b1000, 4'b1000, 4'b1010, 4'b1011};

  initial begin
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_sq_out", 32'(sq_out), 0);
    chk("rst_wrap", 32'(wrap_pulse), 0);
    chk("rst_busy", 32'(commit_busy), 0);
    chk("rst_running", 32'(running), 0);
    #1;
    rst_n = 1'b1;

    // ch2: freq=MOD-1 (near-continuous wraps) with duty 0; ch3: duty=MOD.
    write(0, 10, 0, 50);
    write(1, 20, 25, 50);
    write(2, 99, 0, 0);
    write(3, 10, 0, 100);
    cfg_commit = 1'b1;
    tick();
    repeat (2) tick();

    sq_hist.delete();
    out_en = 1'b1;
    repeat (12) tick();
    chk("first_hist_len", 32'(sq_hist.size()), 12);
    for (int i = 0; i < 12 && i < sq_hist.size(); i++)
      chk($sformatf("first_pattern[%0d]", i), 32'(sq_hist[i]), 32'(first_tbl[i]));
    repeat (20) tick();

    // Commit in RUN: waits for ch0 wrap.
    write(0, 20, 0, 50);
    cfg_commit = 1'b1;
    tick();
    repeat (25) tick();

    // Second commit while busy is absorbed.
    write(1, 10, 40, 60);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b1;
    tick();
    repeat (15) tick();

    // Out-of-range channel write plus commit.
    cfg_commit = 1'b1;
    write(7, 55, 55, 55);
    repeat (15) tick();

    // Drop enable mid-period.
    repeat (3) tick();
    out_en = 1'b0;
    repeat (2) tick();

    // Write and commit in the same IDLE cycle.
    cfg_commit = 1'b1;
    write(1, 10, 0, 30);
    repeat (2) tick();
    out_en = 1'b1;
    repeat (12) tick();

    // Pending commit applied on exit to IDLE; phase >= MOD gets reduced.
    write(2, 99, 150, 0);
    write(0, 10, 50, 50);
    cfg_commit = 1'b1;
    tick();
    repeat (2) tick();
    out_en = 1'b0;
    repeat (3) tick();
    out_en = 1'b1;
    repeat (12) tick();

    // Asynchronous reset mid-run.
    rst_n = 1'b0;
    #1;
    chk("async_rst_sq_out", 32'(sq_out), 0);
    chk("async_rst_wrap", 32'(wrap_pulse), 0);
    chk("async_rst_busy", 32'(commit_busy), 0);
    chk("async_rst_running", 32'(running), 0);
    model_reset();
    @(posedge clk_in);
    #2;
    rst_n = 1'b1;
    cfg_commit = 1'b1;
    tick();
    repeat (10) tick();

    @(posedge clk_in);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
